// File: rtl/reg_file_sb_pkg.sv
// reg_file_sb_pkg
//   Shared widths for the integer register file and its load scoreboard.
//   DATA_WIDTH : register data width
//   REG_WIDTH  : register address width
//   REG_NUM    : number of architectural registers (2**REG_WIDTH)
//   ZERO_REG   : index of the hard-wired zero register x0
package reg_file_sb_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int REG_WIDTH  = 5;
  localparam int REG_NUM    = 2 ** REG_WIDTH;

  localparam logic [REG_WIDTH-1:0] ZERO_REG = '0;

endpackage

// File: rtl/reg_file_sb_scoreboard.sv
// reg_scoreboard
//   Tracks destination registers of loads that have left EX but not yet
//   written back, so decode can stall on an outstanding operand.
//   Ports:
//     clk, rst          : clock, async active-high reset
//     rsX_en/rsX_addr   : read-port lookups from decode
//     ld_issue_en/addr  : load leaving EX, marks its destination busy
//     wb_en/wb_is_load/wb_addr : load write-back, clears the busy mark
//     flush             : cancels every in-flight load
//     rsX_busy          : lookup result, registered state only
//     busy_cnt          : population count of the busy vector
module reg_scoreboard
  import reg_file_sb_pkg::*;
#(
  parameter int REG_WIDTH = reg_file_sb_pkg::REG_WIDTH,
  parameter int REG_NUM   = reg_file_sb_pkg::REG_NUM
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rs1_en,
  input  logic [REG_WIDTH-1:0] rs1_addr,
  input  logic                 rs2_en,
  input  logic [REG_WIDTH-1:0] rs2_addr,
  input  logic                 ld_issue_en,
  input  logic [REG_WIDTH-1:0] ld_issue_addr,
  input  logic                 wb_en,
  input  logic                 wb_is_load,
  input  logic [REG_WIDTH-1:0] wb_addr,
  input  logic                 flush,
  output logic                 rs1_busy,
  output logic                 rs2_busy,
  output logic [REG_WIDTH:0]   busy_cnt
);

  logic [REG_NUM-1:0] busy;
  logic [REG_NUM-1:0] busy_nxt;
  logic [REG_WIDTH:0] cnt_nxt;
  logic               set_v;
  logic               clr_v;
  logic               inc;
  logic               dec;

  assign set_v = ld_issue_en && (ld_issue_addr != ZERO_REG);
  assign clr_v = wb_en && wb_is_load && (wb_addr != ZERO_REG);

  // The counter moves only on real transitions of a busy bit, so it stays
  // equal to popcount(busy) without an adder tree. A clear that collides
  // with a set on the same register is a reissue: the bit stays 1.
  assign inc = set_v && !busy[ld_issue_addr];
  assign dec = clr_v && busy[wb_addr] && !(set_v && (ld_issue_addr == wb_addr));

  always_comb begin
    busy_nxt = busy;
    cnt_nxt  = busy_cnt;
    if (flush) begin
      busy_nxt = '0;
      cnt_nxt  = '0;
    end else begin
      if (clr_v) busy_nxt[wb_addr] = 1'b0;
      if (set_v) busy_nxt[ld_issue_addr] = 1'b1;
      cnt_nxt = busy_cnt + {{REG_WIDTH{1'b0}}, inc} - {{REG_WIDTH{1'b0}}, dec};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      busy     <= busy_nxt;
      busy_cnt <= cnt_nxt;
    end
  end

  assign rs1_busy = rs1_en && (rs1_addr != ZERO_REG) && busy[rs1_addr];
  assign rs2_busy = rs2_en && (rs2_addr != ZERO_REG) && busy[rs2_addr];

endmodule

// File: rtl/reg_file_sb.sv
// reg_file_sb
//   32 x 32 architectural integer register file with two zero-latency read
//   ports, one write-back port and an integrated load scoreboard.
//   Ports:
//     clk, rst                  : clock, async active-high reset
//     rsX_en/rsX_addr/rsX_data  : read ports (x0 and disabled ports read 0)
//     wb_en/wb_addr/wb_data     : write-back port, x0 writes are dropped
//     wb_is_load                : write-back completes a load
//     ld_issue_en/ld_issue_addr : load leaving EX toward MEM
//     flush                     : cancels all in-flight loads
//     rsX_busy, stall           : operand still waiting on a load
//     busy_cnt                  : number of registers marked busy
module reg_file_sb
  import reg_file_sb_pkg::*;
#(
  parameter int DATA_WIDTH = reg_file_sb_pkg::DATA_WIDTH,
  parameter int REG_WIDTH  = reg_file_sb_pkg::REG_WIDTH,
  parameter int REG_NUM    = reg_file_sb_pkg::REG_NUM
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rs1_en,
  input  logic [REG_WIDTH-1:0]  rs1_addr,
  output logic [DATA_WIDTH-1:0] rs1_data,
  input  logic                  rs2_en,
  input  logic [REG_WIDTH-1:0]  rs2_addr,
  output logic [DATA_WIDTH-1:0] rs2_data,
  input  logic                  wb_en,
  input  logic [REG_WIDTH-1:0]  wb_addr,
  input  logic [DATA_WIDTH-1:0] wb_data,
  input  logic                  wb_is_load,
  input  logic                  ld_issue_en,
  input  logic [REG_WIDTH-1:0]  ld_issue_addr,
  input  logic                  flush,
  output logic                  rs1_busy,
  output logic                  rs2_busy,
  output logic                  stall,
  output logic [REG_WIDTH:0]    busy_cnt
);

  logic [DATA_WIDTH-1:0] regs [REG_NUM];

  // x0 is never written, so it holds its reset value of zero; the read
  // muxes still force zero so x0 does not depend on that.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_NUM; i++) regs[i] <= '0;
    end else if (wb_en && (wb_addr != ZERO_REG)) begin
      regs[wb_addr] <= wb_data;
    end
  end

  // No write-through: the bypass stage forwards same-cycle write-backs.
  assign rs1_data = (rs1_en && (rs1_addr != ZERO_REG)) ? regs[rs1_addr] : '0;
  assign rs2_data = (rs2_en && (rs2_addr != ZERO_REG)) ? regs[rs2_addr] : '0;

  reg_scoreboard #(
    .REG_WIDTH (REG_WIDTH),
    .REG_NUM   (REG_NUM)
  ) u_sb (
    .clk           (clk),
    .rst           (rst),
    .rs1_en        (rs1_en),
    .rs1_addr      (rs1_addr),
    .rs2_en        (rs2_en),
    .rs2_addr      (rs2_addr),
    .ld_issue_en   (ld_issue_en),
    .ld_issue_addr (ld_issue_addr),
    .wb_en         (wb_en),
    .wb_is_load    (wb_is_load),
    .wb_addr       (wb_addr),
    .flush         (flush),
    .rs1_busy      (rs1_busy),
    .rs2_busy      (rs2_busy),
    .busy_cnt      (busy_cnt)
  );

  assign stall = rs1_busy | rs2_busy;

endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb
//   Directed bench for reg_file_sb: inputs change on the falling edge, the
//   combinational outputs are sampled 1 ns later, so each sample shows the
//   state left by the preceding rising edge.
module tb_reg_file_sb;

  logic        clk = 1'b0;
  logic        rst;
  logic        rs1_en, rs2_en;
  logic [4:0]  rs1_addr, rs2_addr;
  logic [31:0] rs1_data, rs2_data;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        wb_is_load;
  logic        ld_issue_en;
  logic [4:0]  ld_issue_addr;
  logic        flush;
  logic        rs1_busy, rs2_busy, stall;
  logic [5:0]  busy_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  reg_file_sb dut (
    .clk           (clk),
    .rst           (rst),
    .rs1_en        (rs1_en),
    .rs1_addr      (rs1_addr),
    .rs1_data      (rs1_data),
    .rs2_en        (rs2_en),
    .rs2_addr      (rs2_addr),
    .rs2_data      (rs2_data),
    .wb_en         (wb_en),
    .wb_addr       (wb_addr),
    .wb_data       (wb_data),
    .wb_is_load    (wb_is_load),
    .ld_issue_en   (ld_issue_en),
    .ld_issue_addr (ld_issue_addr),
    .flush         (flush),
    .rs1_busy      (rs1_busy),
    .rs2_busy      (rs2_busy),
    .stall         (stall),
    .busy_cnt      (busy_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    chk(tag, {31'd0, obs}, {31'd0, exp});
  endtask

  task automatic chk_cnt(input string tag, input logic [5:0] exp);
    chk(tag, {26'd0, busy_cnt}, {26'd0, exp});
  endtask

  task automatic idle();
    wb_en = 1'b0; wb_addr = '0; wb_data = '0; wb_is_load = 1'b0;
    ld_issue_en = 1'b0; ld_issue_addr = '0; flush = 1'b0;
  endtask

  task automatic issue(input logic [4:0] a);
    @(negedge clk);
    idle();
    ld_issue_en = 1'b1; ld_issue_addr = a;
  endtask

  initial begin
    rst = 1'b1;
    rs1_en = 1'b1; rs1_addr = 5'd5;
    rs2_en = 1'b1; rs2_addr = 5'd31;
    idle();

    // Reset then read
    repeat (2) @(negedge clk);
    #1;
    chk("rst_rs1_data", rs1_data, 32'h0);
    chk("rst_rs2_data", rs2_data, 32'h0);
    chk_cnt("rst_busy_cnt", 6'd0);
    chk1("rst_stall", stall, 1'b0);
    rst = 1'b0;

    // Write then read, no write-through
    @(negedge clk);
    wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'hDEADBEEF;
    rs1_en = 1'b1; rs1_addr = 5'd7;
    #1 chk("wr_same_cycle", rs1_data, 32'h0);
    @(negedge clk);
    idle();
    #1 chk("wr_next_cycle", rs1_data, 32'hDEADBEEF);
    rs1_en = 1'b0;
    #1 chk("rd_disabled", rs1_data, 32'h0);

    // x0 protection
    @(negedge clk);
    wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFFFFFF;
    ld_issue_en = 1'b1; ld_issue_addr = 5'd0;
    @(negedge clk);
    idle();
    rs1_en = 1'b1; rs1_addr = 5'd0;
    #1;
    chk("x0_read", rs1_data, 32'h0);
    chk_cnt("x0_busy_cnt", 6'd0);
    chk1("x0_busy", rs1_busy, 1'b0);

    // Load issue then load write-back
    issue(5'd3);
    @(negedge clk);
    idle();
    rs2_en = 1'b1; rs2_addr = 5'd3;
    #1;
    chk1("ld3_rs2_busy", rs2_busy, 1'b1);
    chk1("ld3_stall", stall, 1'b1);
    chk_cnt("ld3_busy_cnt", 6'd1);
    wb_en = 1'b1; wb_is_load = 1'b1; wb_addr = 5'd3; wb_data = 32'h12;
    #1 chk1("ld3_busy_same_cycle", rs2_busy, 1'b1);
    @(negedge clk);
    idle();
    #1;
    chk1("wb3_rs2_busy", rs2_busy, 1'b0);
    chk1("wb3_stall", stall, 1'b0);
    chk_cnt("wb3_busy_cnt", 6'd0);
    chk("wb3_rs2_data", rs2_data, 32'h12);

    // Reissue beats concurrent clear on the same register
    issue(5'd4);
    @(negedge clk);
    idle();
    ld_issue_en = 1'b1; ld_issue_addr = 5'd4;
    wb_en = 1'b1; wb_is_load = 1'b1; wb_addr = 5'd4; wb_data = 32'h44;
    @(negedge clk);
    idle();
    rs1_en = 1'b1; rs1_addr = 5'd4;
    #1;
    chk1("setclr4_busy", rs1_busy, 1'b1);
    chk_cnt("setclr4_busy_cnt", 6'd1);
    chk("setclr4_data", rs1_data, 32'h44);

    // Set and clear on different registers: net zero
    issue(5'd6);
    @(negedge clk);
    idle();
    ld_issue_en = 1'b1; ld_issue_addr = 5'd5;
    wb_en = 1'b1; wb_is_load = 1'b1; wb_addr = 5'd6; wb_data = 32'h66;
    #1 chk_cnt("pre_net0_busy_cnt", 6'd2);
    @(negedge clk);
    idle();
    rs1_addr = 5'd5; rs2_addr = 5'd6;
    #1;
    chk_cnt("net0_busy_cnt", 6'd2);
    chk1("net0_x5_busy", rs1_busy, 1'b1);
    chk1("net0_x6_busy", rs2_busy, 1'b0);

    // Non-load write-back to busy x5, clear of idle x7, issue to busy x4
    wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h55;
    @(negedge clk);
    idle();
    wb_en = 1'b1; wb_is_load = 1'b1; wb_addr = 5'd7; wb_data = 32'h77;
    ld_issue_en = 1'b1; ld_issue_addr = 5'd4;
    @(negedge clk);
    idle();
    #1;
    chk1("nonload_x5_busy", rs1_busy, 1'b1);
    chk("nonload_x5_data", rs1_data, 32'h55);
    chk_cnt("noop_busy_cnt", 6'd2);

    // Flush, then three issues, then flush with concurrent issue and write
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    idle();
    #1 chk_cnt("flush0_busy_cnt", 6'd0);
    issue(5'd1);
    issue(5'd2);
    issue(5'd9);
    @(negedge clk);
    idle();
    #1 chk_cnt("three_busy_cnt", 6'd3);
    flush = 1'b1;
    ld_issue_en = 1'b1; ld_issue_addr = 5'd10;
    wb_en = 1'b1; wb_addr = 5'd11; wb_data = 32'hAB;
    @(negedge clk);
    idle();
    rs1_addr = 5'd10; rs2_addr = 5'd11;
    #1;
    chk_cnt("flush_busy_cnt", 6'd0);
    chk1("flush_x10_busy", rs1_busy, 1'b0);
    chk("flush_wb_x11", rs2_data, 32'hAB);

    // Reissue, then async reset between edges
    issue(5'd1);
    issue(5'd2);
    issue(5'd9);
    @(negedge clk);
    idle();
    rs1_addr = 5'd1; rs2_addr = 5'd7;
    #1;
    chk_cnt("pre_rst_busy_cnt", 6'd3);
    chk1("pre_rst_stall", stall, 1'b1);
    chk("pre_rst_x7", rs2_data, 32'h77);
    #1 rst = 1'b1;
    #1;
    chk_cnt("arst_busy_cnt", 6'd0);
    chk1("arst_rs1_busy", rs1_busy, 1'b0);
    chk1("arst_stall", stall, 1'b0);
    chk("arst_x7", rs2_data, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Architectural integer register file: 32 x 32 bits, two read ports, one write-back port.
- Read ports are the responder end of the bypass read interface (`*_en` / `*_addr` / `*_data`). The write port is driven by the WB stage.
- An integrated load scoreboard tracks destinations of in-flight loads. It tells decode when an operand is still outstanding so decode can stall instead of forwarding.

Parameters:
- DATA_WIDTH, 32, register data width (shared `DATA_WIDTH`).
- REG_WIDTH, 5, register address width (shared `REG_WIDTH`).
- REG_NUM, 32, number of registers (2**REG_WIDTH).

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- rs1_en  in  1  read port 1 enable.
- rs1_addr  in  REG_WIDTH  read port 1 address.
- rs1_data  out  DATA_WIDTH  read port 1 data.
- rs2_en  in  1  read port 2 enable.
- rs2_addr  in  REG_WIDTH  read port 2 address.
- rs2_data  out  DATA_WIDTH  read port 2 data.
- wb_en  in  1  write-back enable.
- wb_addr  in  REG_WIDTH  write-back destination.
- wb_data  in  DATA_WIDTH  write-back data.
- wb_is_load  in  1  this write-back completes a load.
- ld_issue_en  in  1  a load leaves EX toward MEM.
- ld_issue_addr  in  REG_WIDTH  destination register of that load.
- flush  in  1  pipeline flush; cancels all in-flight loads.
- rs1_busy  out  1  rs1 operand has a load outstanding.
- rs2_busy  out  1  rs2 operand has a load outstanding.
- stall  out  1  rs1_busy | rs2_busy.
- busy_cnt  out  REG_WIDTH+1  number of registers currently marked busy.

Behaviour:
- Reset (async, rst=1):
  - all registers = 0; busy[31:0] = 0; busy_cnt = 0.
  - Combinational outputs follow: rsX_data = 0, rsX_busy = 0, stall = 0.
  - Reset asserted mid-operation discards pending writes and scoreboard state immediately.
- Read, combinational, zero latency:
  - rsX_data = 0 if rsX_en=0 or rsX_addr=0; otherwise regs[rsX_addr].
  - No write-through: a same-cycle write is not visible until the next cycle. The bypass stage covers that case.
- Write, at the rising edge: if wb_en=1 and wb_addr!=0, then regs[wb_addr] <= wb_data. Writes to x0 are dropped; x0 always reads 0.
- Scoreboard update, per rising edge, evaluated in this priority:
  1. flush=1: busy <= 0 and busy_cnt <= 0. Any issue or clear in the same cycle is ignored. The WB register write still happens.
  2. Set: ld_issue_en=1 and ld_issue_addr!=0 sets busy[ld_issue_addr].
  3. Clear: wb_en=1, wb_is_load=1 and wb_addr!=0 clears busy[wb_addr].
  4. Set and clear to the same address in one cycle: set wins, and busy stays 1 (a younger load reissued the register).
- busy_cnt is a registered counter and always equals popcount(busy):
  - +1 when a set hits a non-busy register.
  - -1 when a clear hits a busy register (and that register is not also being set).
  - Both in one cycle on different registers: net 0.
  - Issue to an already-busy register, or a clear of a non-busy register: no change.
  - Cannot overflow, since x0 is never busy (maximum 31).
- Busy outputs, combinational:
  - rsX_busy = rsX_en & (rsX_addr!=0) & busy[rsX_addr].
  - They reflect the registered state only; same-cycle set/clear takes effect next cycle.
  - stall = rs1_busy | rs2_busy.
- A non-load write-back to a busy register leaves the busy bit unchanged.

Decomposition:
- Shared package/include (width_param): `DATA_WIDTH`, `REG_WIDTH`, `REG_NUM`, constant `ZERO_REG` = 0.
- Sub-module `reg_scoreboard`: busy vector, busy_cnt and rsX_busy logic, with its own clk/rst.
- Register array and read muxes stay in the top module.

Test Plan:
- Reset then read: rst pulse; read rs1_addr=5, rs2_addr=31 with enables high -> both data 0; busy_cnt=0; stall=0.
- Write then read: wb write x7=0xDEADBEEF.
  - Same-cycle rs1_addr=7 -> old value 0.
  - Next cycle -> 0xDEADBEEF.
  - rs1_en=0 -> 0.
- x0 protection: wb write x0=0xFFFFFFFF and ld_issue to x0 -> rs1_addr=0 reads 0; busy_cnt stays 0.
- Load scoreboard:
  - Issue x3, then read rs2_addr=3 -> rs2_busy=1, stall=1, busy_cnt=1.
  - wb_is_load write x3=0x12 -> next cycle busy=0, busy_cnt=0, rs2_data=0x12.
- Simultaneous events:
  - Same cycle: issue x4 while the load write-back to x4 arrives -> busy[4] stays 1, busy_cnt unchanged.
  - Same cycle: issue x5 plus clear of busy x6 -> busy_cnt net 0.
- Flush and async reset:
  - Issue x1, x2, x9 -> busy_cnt=3.
  - flush with a concurrent issue of x10 -> busy_cnt=0 and x10 not busy.
  - Repeat the issues, then assert rst mid-cycle (between edges) -> outputs clear immediately.
